micro_ucr_nonce_ctrl: RTL

//  Nonce-search controller that sits directly upstream of the micro_ucr_hash core.
//  It builds the 128-bit block {payload, nonce}, watches the core's round counter and

---
 rtl/micro_ucr_nonce_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/micro_ucr_nonce_ctrl.sv
// Nonce-search controller for the micro_ucr_hash core: drives {payload, nonce} into the core,
// samples the digest at each round boundary, and parks the core on a hit or when the range runs out.
`timescale 1ns/1ps

module micro_ucr_nonce_ctrl #(
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         start,
    input  logic [95:0]  payload,
    input  logic [7:0]   target,
    input  logic [5:0]   core_count,
    input  logic [23:0]  core_H,
    output logic         core_reset_L,
    output logic [127:0] bloque_out,
    output logic         fin_out,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  nonce_out,
    output logic [23:0]  hash_out,
    output logic [31:0]  attempts
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned NONCE_W = 32;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(34);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_CORE = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state;
    logic [NONCE_W-1:0]   nonce_q;
    logic [CNT_W-1:0]     prev_count;
    logic                 round_done_c;
    logic                 hit_c;

    // The core wraps 34 -> 0 at the end of a round; core_H is only valid in that cycle.
    assign round_done_c = (prev_count == LAST_COUNT) && (core_count == '0);
    assign hit_c        = (core_H[23:16] < target) && (core_H[15:8] < target);
    assign bloque_out   = {payload, nonce_q};

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            core_reset_L <= 1'b0;
            fin_out      <= 1'b1;
            busy         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            nonce_q      <= NONCE_START;
            nonce_out    <= '0;
            hash_out     <= '0;
            attempts     <= '0;
            prev_count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RST_CORE;
                        core_reset_L <= 1'b0;
                        fin_out      <= 1'b0;
                        busy         <= 1'b1;
                        found        <= 1'b0;
                        exhausted    <= 1'b0;
                        nonce_q      <= NONCE_START;
                        attempts     <= '0;
                        prev_count   <= '0;
                    end
                end
                RST_CORE: begin
                    state        <= RUN;
                    core_reset_L <= 1'b1;
                end
                RUN: begin
                    prev_count <= core_count;
                    if (round_done_c) begin
                        attempts <= attempts + 32'd1;
                        // A hit on the last nonce still reports found, never exhausted.
                        if (hit_c) begin
                            nonce_out <= nonce_q;
                            hash_out  <= core_H;
                            found     <= 1'b1;
                            fin_out   <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else if (nonce_q == NONCE_LAST) begin
                            exhausted <= 1'b1;
                            fin_out   <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
